pushbutton_array_processor: RTL and testbench



---
 rtl/pushbutton_pkg.sv | 15 +
 rtl/pushbutton_channel.sv | 128 ++++++++++++
 rtl/pushbutton_array_processor.sv | 34 +++
 tb/tb_pushbutton_array_processor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pushbutton_pkg.sv
// Shared definitions for the pushbutton array: press FSM encoding and counter sizing.
package pushbutton_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } press_state_e;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pushbutton_channel.sv
// One button channel: 2-FF synchroniser, debouncer and short/long press classifier.
// Optional auto-repeat of count_down while long-held: define PUSHBUTTON_AUTOREPEAT_EN.
module pushbutton_channel
    import pushbutton_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 2000,
    parameter int REPEAT_MS   = 250
) (
    input  logic clk_1khz,
    input  logic rst_i,
    input  logic pushbutton_i,
    output logic pressed,
    output logic count_up,
    output logic count_down
);
    localparam int DB_W   = cnt_w(DEBOUNCE_MS);
    localparam int HOLD_W = cnt_w(LONG_MS);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

    if (DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS || REPEAT_MS < 1) begin : g_bad_params
        $error("pushbutton_channel: invalid timing parameters");
    end

    logic              s1_q, s2_q;
    logic              pressed_q, pressed_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    press_state_e      state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              up_q, up_d, down_q, down_d;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
    localparam int REP_W = cnt_w(REPEAT_MS);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

    always_comb begin
        pressed_d = pressed_q;
        db_cnt_d  = db_cnt_q;
        if (s2_q == pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            pressed_d = s2_q;
            db_cnt_d  = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // The FSM reacts to the debouncer's next value so pulses land exactly
    // LONG_MS cycles after the debounced rise; release beats the long threshold.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        up_d       = 1'b0;
        down_d     = 1'b0;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pressed_d) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                end
            end
            HELD: begin
                if (!pressed_d) begin
                    up_d    = 1'b1;
                    state_d = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    down_d  = 1'b1;
                    state_d = LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            LONG: begin
                if (!pressed_d) begin
                    state_d = IDLE;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    down_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            pressed_q  <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            s1_q       <= pushbutton_i;
            s2_q       <= s1_q;
            pressed_q  <= pressed_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            up_q       <= up_d;
            down_q     <= down_d;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
`endif
        end
    end

    assign pressed    = pressed_q;
    assign count_up   = up_q;
    assign count_down = down_q;

endmodule

// File: rtl/pushbutton_array_processor.sv
// N_CH independent pushbutton channels in the clk_1khz domain.
// Optional auto-repeat of count_down while long-held: define PUSHBUTTON_AUTOREPEAT_EN.
module pushbutton_array_processor
    import pushbutton_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 2000,
    parameter int REPEAT_MS   = 250
) (
    input  logic            clk_1khz,
    input  logic            rst_i,
    input  logic [N_CH-1:0] pushbutton_i,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] count_up,
    output logic [N_CH-1:0] count_down
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pushbutton_channel #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS),
            .REPEAT_MS  (REPEAT_MS)
        ) u_ch (
            .clk_1khz    (clk_1khz),
            .rst_i       (rst_i),
            .pushbutton_i(pushbutton_i[g]),
            .pressed     (pressed[g]),
            .count_up    (count_up[g]),
            .count_down  (count_down[g])
        );
    end

endmodule

// File: tb/tb_pushbutton_array_processor.sv
// Randomised and directed bench for pushbutton_array_processor against a press-duration model.
module tb_pushbutton_array_processor;
    localparam int N_CH = 2;
    localparam int DEB  = 20;
    localparam int LNG  = 2000;
    localparam int REP  = 250;

    logic            clk_1khz = 1'b0;
    logic            rst_i;
    logic [N_CH-1:0] pushbutton_i;
    logic [N_CH-1:0] pressed, count_up, count_down;

    pushbutton_array_processor #(
        .N_CH(N_CH), .DEBOUNCE_MS(DEB), .LONG_MS(LNG), .REPEAT_MS(REP)
    ) dut (
        .clk_1khz    (clk_1khz),
        .rst_i       (rst_i),
        .pushbutton_i(pushbutton_i),
        .pressed     (pressed),
        .count_up    (count_up),
        .count_down  (count_down)
    );

    always #5 clk_1khz = ~clk_1khz;

    // Model: a level change is accepted once DEB consecutive raw samples (seen
    // two cycles late through the synchroniser) differ from the current level;
    // pulses are derived from how long the debounced level has been high.
    int              cyc = 0;
    logic [63:0]     hist [N_CH];
    logic [N_CH-1:0] m_pressed, m_up, m_down, m_long;
    int              m_start [N_CH];

    always @(posedge clk_1khz) begin : model
        int   n, held;
        logic p, up, dn, diff;
        n = cyc + 1;
        for (int c = 0; c < N_CH; c++) begin
            up = 1'b0;
            dn = 1'b0;
            p  = m_pressed[c];
            if (rst_i) begin
                hist[c] <= '0;
                p = 1'b0;
            end else begin
                diff = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (hist[c][j] == p) diff = 1'b0;
                hist[c] <= {hist[c][62:0], pushbutton_i[c]};
                if (diff) begin
                    p = !p;
                    if (p) begin
                        m_start[c] <= n;
                        m_long[c]  <= 1'b0;
                    end else if (!m_long[c]) begin
                        up = 1'b1;
                    end
                end else if (p) begin
                    held = n - m_start[c];
                    if (held == LNG) begin
                        dn = 1'b1;
                        m_long[c] <= 1'b1;
                    end
`ifdef PUSHBUTTON_AUTOREPEAT_EN
                    else if (held > LNG && (held - LNG) % REP == 0) dn = 1'b1;
`endif
                end
            end
            m_pressed[c] <= p;
            m_up[c]      <= up;
            m_down[c]    <= dn;
        end
        cyc <= n;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    logic [N_CH-1:0] prev_p = '0;
    int rise_cyc [N_CH];
    int fall_cyc [N_CH];
    int down_cyc [N_CH];
    int up_n [N_CH];
    int down_n [N_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance to the next falling edge, compare against the model, log events.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_1khz);
            if (cmp_en)
                for (int c = 0; c < N_CH; c++) begin
                    chk($sformatf("pressed ch%0d", c), 32'(pressed[c]), 32'(m_pressed[c]));
                    chk($sformatf("count_up ch%0d", c), 32'(count_up[c]), 32'(m_up[c]));
                    chk($sformatf("count_down ch%0d", c), 32'(count_down[c]), 32'(m_down[c]));
                end
            for (int c = 0; c < N_CH; c++) begin
                if (pressed[c] === 1'b1 && !prev_p[c]) rise_cyc[c] = cyc;
                if (pressed[c] === 1'b0 && prev_p[c]) fall_cyc[c] = cyc;
                if (count_up[c] === 1'b1) up_n[c]++;
                if (count_down[c] === 1'b1) begin
                    down_n[c]++;
                    down_cyc[c] = cyc;
                end
            end
            prev_p = pressed;
        end
    endtask

    function automatic int pick_len();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return $urandom_range(1, 6);
        if (r < 7) return $urandom_range(15, 60);
        if (r == 7) return $urandom_range(1990, 2010);
        if (r == 8) return $urandom_range(2240, 2260);
        return $urandom_range(100, 600);
    endfunction

    initial begin
        int t0, r0, u0, d0, u1, d1;
        int rem [N_CH];
        logic [N_CH-1:0] raw;
        int seq_v [6] = '{1, 0, 1, 0, 1, 0};
        int seq_l [6] = '{1, 2, 1, 2, 2, 1};
        for (int c = 0; c < N_CH; c++) begin
            up_n[c] = 0; down_n[c] = 0; rise_cyc[c] = 0; fall_cyc[c] = 0; down_cyc[c] = 0;
        end
        rst_i = 1'b1;
        pushbutton_i = '0;
        tick(3);
        chk("reset pressed", 32'(pressed), 32'd0);
        chk("reset count_up", 32'(count_up), 32'd0);
        chk("reset count_down", 32'(count_down), 32'd0);
        cmp_en = 1'b1;
        rst_i = 1'b0;
        tick(5);

        // Bounce rejection, then a 30-cycle stable press.
        for (int i = 0; i < 6; i++) begin
            pushbutton_i[0] = seq_v[i][0];
            tick(seq_l[i]);
        end
        u0 = up_n[0]; d0 = down_n[0];
        pushbutton_i[0] = 1'b1; t0 = cyc;
        tick(30);
        pushbutton_i[0] = 1'b0; r0 = cyc;
        tick(60);
        chk("bounce rise latency", rise_cyc[0] - t0, 32'd22);
        chk("bounce fall latency", fall_cyc[0] - r0, 32'd22);
        chk("bounce up pulses", up_n[0] - u0, 32'd1);
        chk("bounce down pulses", down_n[0] - d0, 32'd0);

        // Long press.
        u0 = up_n[0]; d0 = down_n[0];
        pushbutton_i[0] = 1'b1;
        tick(2100);
        pushbutton_i[0] = 1'b0;
        tick(60);
        chk("long down pulses", down_n[0] - d0, 32'd1);
        chk("long down timing", down_cyc[0] - rise_cyc[0], 32'd2000);
        chk("long up pulses", up_n[0] - u0, 32'd0);

        // Boundary: 2000 cycles held is short, 2001 is long.
        u0 = up_n[0]; d0 = down_n[0];
        pushbutton_i[0] = 1'b1;
        tick(2000);
        pushbutton_i[0] = 1'b0;
        tick(60);
        chk("boundary held", fall_cyc[0] - rise_cyc[0], 32'd2000);
        chk("boundary short up", up_n[0] - u0, 32'd1);
        chk("boundary short down", down_n[0] - d0, 32'd0);
        u0 = up_n[0]; d0 = down_n[0];
        pushbutton_i[0] = 1'b1;
        tick(2001);
        pushbutton_i[0] = 1'b0;
        tick(60);
        chk("boundary long up", up_n[0] - u0, 32'd0);
        chk("boundary long down", down_n[0] - d0, 32'd1);

        // Overlapping channels released together.
        u0 = up_n[0]; d0 = down_n[0]; u1 = up_n[1]; d1 = down_n[1];
        pushbutton_i[1] = 1'b1;
        tick(1000);
        pushbutton_i[0] = 1'b1;
        tick(1200);
        pushbutton_i = '0; r0 = cyc;
        tick(60);
        chk("dual ch0 up", up_n[0] - u0, 32'd1);
        chk("dual ch0 down", down_n[0] - d0, 32'd0);
        chk("dual ch1 up", up_n[1] - u1, 32'd0);
        chk("dual ch1 down", down_n[1] - d1, 32'd1);
        chk("dual ch0 fall", fall_cyc[0] - r0, 32'd22);
        chk("dual ch1 fall", fall_cyc[1] - r0, 32'd22);

        // Reset in the middle of a held press.
        u0 = up_n[0]; d0 = down_n[0];
        pushbutton_i[0] = 1'b1;
        tick(1522);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0; t0 = cyc;
        chk("midreset pressed", 32'(pressed), 32'd0);
        chk("midreset pulses", 32'({count_up, count_down}), 32'd0);
        tick(2100);
        chk("midreset rise latency", rise_cyc[0] - t0, 32'd22);
        chk("midreset down timing", down_cyc[0] - rise_cyc[0], 32'd2000);
        pushbutton_i[0] = 1'b0;
        tick(60);
        chk("midreset down pulses", down_n[0] - d0, 32'd1);
        chk("midreset up pulses", up_n[0] - u0, 32'd0);

        // 3000-cycle hold: repeats only when auto-repeat is built in.
        u1 = up_n[1]; d1 = down_n[1];
        pushbutton_i[1] = 1'b1;
        tick(3000);
        pushbutton_i[1] = 1'b0;
        tick(60);
`ifdef PUSHBUTTON_AUTOREPEAT_EN
        chk("hold3s down pulses", down_n[1] - d1, 32'd4);
        chk("hold3s last down", down_cyc[1] - rise_cyc[1], 32'd2750);
`else
        chk("hold3s down pulses", down_n[1] - d1, 32'd1);
        chk("hold3s last down", down_cyc[1] - rise_cyc[1], 32'd2000);
`endif
        chk("hold3s up pulses", up_n[1] - u1, 32'd0);

        // Random segments per channel with occasional resets.
        raw = '0;
        for (int c = 0; c < N_CH; c++) rem[c] = $urandom_range(1, 50);
        repeat (20000) begin
            for (int c = 0; c < N_CH; c++) begin
                if (rem[c] == 0) begin
                    raw[c] = ~raw[c];
                    rem[c] = pick_len();
                end else begin
                    rem[c]--;
                end
            end
            pushbutton_i = raw;
            rst_i = ($urandom_range(0, 4999) == 0);
            tick(1);
        end
        rst_i = 1'b0;
        pushbutton_i = '0;
        tick(100);
        chk("final pressed", 32'(pressed), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
